edge_generator: RTL and testbench

EDGE_GENERATOR -- requirements
Module: edge_generator

---
 rtl/edge_generator.sv | 129 ++++++++++++
 tb/tb_edge_generator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/edge_generator.sv
// rtl/edge_generator.sv - programmable pulse-train generator (high/low lengths, pulse count, abort)
module edge_generator #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] high_cycles_i,
  input  logic [CNT_W-1:0] low_cycles_i,
  input  logic [NUM_W-1:0] num_pulses_i,
  input  logic             abort_i,
  output logic             signal_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] pulse_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);
  localparam logic [NUM_W-1:0] NUM_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [NUM_W-1:0] num_pulses;
  logic [CNT_W-1:0] phase_cnt;

  // Phase counter is loaded with (length - 1); a zero length behaves as one cycle.
  logic [CNT_W-1:0] high_reload_in;
  logic [CNT_W-1:0] high_reload;
  logic [CNT_W-1:0] low_reload;
  logic [NUM_W-1:0] cnt_next;
  logic             more_pulses;
  logic             phase_end;

  // Reload values, saturating pulse count and end-of-phase detection
  always_comb begin
    high_reload_in = (high_cycles_i == '0) ? '0 : high_cycles_i - CNT_ONE;
    high_reload    = (high_len == '0) ? '0 : high_len - CNT_ONE;
    low_reload     = (low_len == '0) ? '0 : low_len - CNT_ONE;
    cnt_next       = (pulse_cnt_o == NUM_MAX) ? pulse_cnt_o : pulse_cnt_o + NUM_ONE;
    more_pulses    = (cnt_next < num_pulses);
    phase_end      = (phase_cnt == '0);
  end

  // Train FSM with registered waveform, busy, done and completed-pulse count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      high_len    <= '0;
      low_len     <= '0;
      num_pulses  <= '0;
      phase_cnt   <= '0;
      pulse_cnt_o <= '0;
      signal_o    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // Abort in idle only matters as a veto on a simultaneous start.
          if (start_i && !abort_i) begin
            pulse_cnt_o <= '0;
            if (num_pulses_i == '0) begin
              // Empty train: report completion without touching the waveform.
              done_o <= 1'b1;
            end else begin
              high_len   <= high_cycles_i;
              low_len    <= low_cycles_i;
              num_pulses <= num_pulses_i;
              phase_cnt  <= high_reload_in;
              state      <= S_HIGH;
              signal_o   <= 1'b1;
              busy_o     <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (abort_i) begin
            state    <= S_IDLE;
            signal_o <= 1'b0;
            busy_o   <= 1'b0;
          end else if (phase_end) begin
            state     <= S_LOW;
            signal_o  <= 1'b0;
            phase_cnt <= low_reload;
          end else begin
            phase_cnt <= phase_cnt - CNT_ONE;
          end
        end
        S_LOW: begin
          if (abort_i) begin
            state    <= S_IDLE;
            signal_o <= 1'b0;
            busy_o   <= 1'b0;
          end else if (phase_end) begin
            // A pulse is complete once its low phase has fully elapsed.
            pulse_cnt_o <= cnt_next;
            if (more_pulses) begin
              state     <= S_HIGH;
              signal_o  <= 1'b1;
              phase_cnt <= high_reload;
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt - CNT_ONE;
          end
        end
        default: begin
          state    <= S_IDLE;
          signal_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// tb/tb_edge_generator.sv - scoreboard bench for edge_generator against a waveform-plan model
module tb_edge_generator;

  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] high_cycles = '0;
  logic [CNT_W-1:0] low_cycles = '0;
  logic [NUM_W-1:0] num_pulses = '0;
  logic             abort = 1'b0;
  logic             signal;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_cnt;

  always #5 clk = ~clk;

  edge_generator #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .high_cycles_i(high_cycles),
    .low_cycles_i (low_cycles),
    .num_pulses_i (num_pulses),
    .abort_i      (abort),
    .signal_o     (signal),
    .busy_o       (busy),
    .done_o       (done),
    .pulse_cnt_o  (pulse_cnt)
  );

  typedef struct {
    logic             sig;
    logic             bsy;
    logic             dn;
    logic [NUM_W-1:0] cnt;
    int               tgt;
  } exp_t;

  exp_t             plan[$];
  exp_t             expq[$];
  int               cyc = 0;
  int               tests = 0;
  int               fails = 0;
  logic [NUM_W-1:0] last_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(logic s, logic b, logic d, logic [NUM_W-1:0] c);
    exp_t e;
    e.sig = s;
    e.bsy = b;
    e.dn  = d;
    e.cnt = c;
    e.tgt = 0;
    return e;
  endfunction

  // Applies one cycle of inputs, predicts the output after the next edge, then advances.
  task automatic drive(input logic st, input int h, input int l, input int n,
                       input logic ab, input logic rs);
    exp_t e;
    int he;
    int le;
    start       = st;
    high_cycles = CNT_W'(h);
    low_cycles  = CNT_W'(l);
    num_pulses  = NUM_W'(n);
    abort       = ab;
    rst         = rs;
    if (rs) begin
      plan.delete();
      e = mk(1'b0, 1'b0, 1'b0, '0);
    end else if (plan.size() > 0) begin
      if (ab) begin
        plan.delete();
        e = mk(1'b0, 1'b0, 1'b0, last_cnt);
      end else begin
        e = plan.pop_front();
      end
    end else if (st && !ab) begin
      if (n == 0) begin
        e = mk(1'b0, 1'b0, 1'b1, '0);
      end else begin
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        for (int p = 0; p < n; p++) begin
          for (int i = 0; i < he; i++) plan.push_back(mk(1'b1, 1'b1, 1'b0, NUM_W'(p)));
          for (int i = 0; i < le; i++) plan.push_back(mk(1'b0, 1'b1, 1'b0, NUM_W'(p)));
        end
        plan.push_back(mk(1'b0, 1'b0, 1'b1, NUM_W'(n)));
        e = plan.pop_front();
      end
    end else begin
      e = mk(1'b0, 1'b0, 1'b0, last_cnt);
    end
    last_cnt = e.cnt;
    e.tgt = cyc + 1;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int k);
    for (int i = 0; i < k; i++)
      drive(1'b0, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
            int'($urandom_range(0, 9)), 1'b0, 1'b0);
  endtask

  // Monitor: compares every observed cycle against the queued expectation for that cycle
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].tgt <= cyc) begin
      e = expq.pop_front();
      tests++;
      if (signal !== e.sig || busy !== e.bsy || done !== e.dn || pulse_cnt !== e.cnt) begin
        fails++;
        $display("FAIL cycle%0d outputs: got sig=%b busy=%b done=%b cnt=%0d, want sig=%b busy=%b done=%b cnt=%0d",
                 cyc, signal, busy, done, pulse_cnt, e.sig, e.bsy, e.dn, e.cnt);
      end
    end
  end

  initial begin
    logic st;
    logic ab;
    logic rs;
    @(posedge clk);
    #1;
    // Reset state
    repeat (3) drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    quiet(2);
    // H=3 L=2 N=4
    drive(1'b1, 3, 2, 4, 1'b0, 1'b0);
    quiet(23);
    // Zero lengths behave as one
    drive(1'b1, 0, 0, 2, 1'b0, 1'b0);
    quiet(6);
    // Empty train
    drive(1'b1, 5, 5, 0, 1'b0, 1'b0);
    quiet(3);
    // Abort in second high phase
    drive(1'b1, 4, 4, 3, 1'b0, 1'b0);
    quiet(9);
    drive(1'b0, 1, 1, 1, 1'b1, 1'b0);
    quiet(5);
    // Restart attempt while busy
    drive(1'b1, 2, 2, 2, 1'b0, 1'b0);
    quiet(2);
    drive(1'b1, 7, 1, 9, 1'b0, 1'b0);
    quiet(8);
    // Abort alone in idle, abort beats start in idle
    drive(1'b0, 2, 2, 2, 1'b1, 1'b0);
    drive(1'b1, 2, 2, 2, 1'b1, 1'b0);
    quiet(2);
    // Reset mid-train then a short train; reset beats start
    drive(1'b1, 3, 3, 5, 1'b0, 1'b0);
    quiet(4);
    drive(1'b1, 2, 2, 2, 1'b1, 1'b1);
    drive(1'b1, 1, 1, 1, 1'b0, 1'b0);
    quiet(4);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 199) == 0);
      drive(st, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 4)), ab, rs);
    end
    quiet(40);
    @(negedge clk);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
